// File: rtl/linebuf_pkg.sv
// Shared definitions for the double-buffered sprite line buffer.
// Used by the scanout engine and by the sprite writer on the other bank.
package linebuf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        CAPT = 2'd2
    } state_t;

    localparam int BANK_W     = 1;
    localparam int COL_W_DEF  = 8;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = BANK_W + COL_W_DEF;

    localparam logic [DATA_W_DEF-1:0] CLEAR_VAL_DEF = '0;

endpackage

// File: rtl/linebuf_scanout_if.sv
// Port B of the line buffer RAM: registered read, one-clock latency.
// The master drives address and control, the RAM returns ram_q.
interface linebuf_scanout_if
    import linebuf_pkg::*;
#(
    parameter int COL_W  = COL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              ram_en;
    logic              ram_wr;
    logic [COL_W:0]    ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    modport master (
        output ram_en,
        output ram_wr,
        output ram_addr,
        output ram_wdata,
        input  ram_q
    );

    modport slave (
        input  ram_en,
        input  ram_wr,
        input  ram_addr,
        input  ram_wdata,
        output ram_q
    );

endinterface

// File: rtl/linebuf_scanout.sv
// Scans the display bank one pixel per ce_pix and erases each
// location behind the read, so the bank is empty when it flips.
module linebuf_scanout
    import linebuf_pkg::*;
#(
    parameter int                COL_W     = COL_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                LINE_LEN  = 256,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(CLEAR_VAL_DEF)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic               line_start,
    linebuf_scanout_if.master  ram,
    output logic [DATA_W-1:0]  pix_out,
    output logic               pix_valid,
    output logic               wr_bank,
    output logic               busy,
    output logic               overrun
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);

    state_t           state;
    logic             bank;
    logic [COL_W-1:0] col;
    logic             rd_go;
    logic             clr_go;

    // line_start wins over a coincident ce_pix, so no read is issued
    assign rd_go  = (state == SCAN) && ce_pix && !line_start && !reset;
    assign clr_go = (state == CAPT) && !reset;

    assign ram.ram_en    = rd_go || clr_go;
    assign ram.ram_wr    = clr_go;
    assign ram.ram_addr  = {bank, col};
    assign ram.ram_wdata = CLEAR_VAL;

    assign wr_bank = ~bank;
    assign busy    = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bank      <= 1'b0;
            col       <= '0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (ce_pix) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    pix_out   <= ram.ram_q;
                    pix_valid <= 1'b1;
                    if (ce_pix) begin
                        overrun <= 1'b1;
                    end
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= IDLE;
                    end else begin
                        col   <= col + 1'b1;
                        state <= SCAN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // capture and clear-write above still complete in CAPT
            if (line_start) begin
                bank  <= ~bank;
                col   <= '0;
                state <= SCAN;
            end
        end
    end

endmodule

// File: tb/tb_linebuf_scanout.sv
// Bench for linebuf_scanout: RAM model on both ports, transaction-level
// reference of bank contents, bank/column and the sticky overrun flag.
module tb_linebuf_scanout;
    import linebuf_pkg::*;

    localparam int         COL_W    = 8;
    localparam int         DATA_W   = 8;
    localparam int         LINE_LEN = 200;
    localparam int         DEPTH    = 2 ** (COL_W + 1);
    localparam logic [7:0] CLR      = 8'h00;

    logic             clock = 1'b0;
    logic             reset;
    logic             ce_pix;
    logic             line_start;
    logic [7:0]       pix_out;
    logic             pix_valid;
    logic             wr_bank;
    logic             busy;
    logic             overrun;

    logic [7:0]       ram [DEPTH];
    logic             ram_init;
    logic             pa_we;
    logic [COL_W:0]   pa_addr;
    logic [7:0]       pa_wdata;

    logic [7:0]       mdl [DEPTH];
    logic             mbank;
    logic             mbusy;
    logic             movr;
    int               mcol;

    int               n_pass = 0;
    int               n_chk  = 0;

    always #5 clock = ~clock;

    linebuf_scanout_if #(.COL_W(COL_W), .DATA_W(DATA_W)) bus ();

    linebuf_scanout #(
        .COL_W    (COL_W),
        .DATA_W   (DATA_W),
        .LINE_LEN (LINE_LEN),
        .CLEAR_VAL(CLR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .line_start(line_start),
        .ram       (bus.master),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .wr_bank   (wr_bank),
        .busy      (busy),
        .overrun   (overrun)
    );

    // dual-port RAM: port A for the sprite writer, port B for the DUT
    always @(posedge clock) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else begin
            if (pa_we) ram[pa_addr] <= pa_wdata;
            if (bus.ram_en) begin
                if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_wdata;
                bus.ram_q <= ram[bus.ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic wr_pix(input int c, input logic [7:0] d);
        logic [COL_W:0] a;
        a = {!mbank, 8'(c)};
        pa_we = 1'b1;
        pa_addr = a;
        pa_wdata = d;
        @(negedge clock);
        pa_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic do_line_start();
        line_start = 1'b1;
        @(negedge clock);
        line_start = 1'b0;
        #1;
        mbank = !mbank;
        mcol = 0;
        mbusy = 1'b1;
        chk("ls_wr_bank", wr_bank, !mbank);
        chk("ls_busy", busy, mbusy);
    endtask

    // mode 0: plain read; 1: ce_pix repeated in CAPT; 2: line_start in CAPT
    task automatic do_pix(input int mode);
        logic [COL_W:0] ea;
        logic [7:0]     ed;
        ea = {mbank, 8'(mcol)};
        ed = mdl[ea];
        ce_pix = 1'b1;
        #1;
        chk("rd_en", bus.ram_en, 1);
        chk("rd_wr", bus.ram_wr, 0);
        chk("rd_addr", bus.ram_addr, ea);
        @(negedge clock);
        ce_pix = (mode == 1);
        line_start = (mode == 2);
        #1;
        chk("clr_en", bus.ram_en, 1);
        chk("clr_wr", bus.ram_wr, 1);
        chk("clr_addr", bus.ram_addr, ea);
        chk("clr_data", bus.ram_wdata, CLR);
        chk("valid_early", pix_valid, 0);
        @(negedge clock);
        ce_pix = 1'b0;
        line_start = 1'b0;
        #1;
        chk("pix_valid", pix_valid, 1);
        chk("pix_out", pix_out, ed);
        mdl[ea] = CLR;
        if (mode == 1) movr = 1'b1;
        if (mode == 2) begin
            mbank = !mbank;
            mcol = 0;
            mbusy = 1'b1;
        end else if (mcol == LINE_LEN - 1) begin
            mcol = 0;
            mbusy = 1'b0;
        end else begin
            mcol++;
        end
        chk("busy", busy, mbusy);
        chk("wr_bank", wr_bank, !mbank);
        chk("overrun", overrun, movr);
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
            chk("gap_valid", pix_valid, 0);
        end
    endtask

    task automatic idle_ce();
        ce_pix = 1'b1;
        #1;
        chk("idle_en", bus.ram_en, 0);
        @(negedge clock);
        ce_pix = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        @(negedge clock);
        #1;
        chk("idle_valid", pix_valid, 0);
    endtask

    initial begin
        int diffs;
        reset = 1'b1;
        ram_init = 1'b1;
        ce_pix = 1'b0;
        line_start = 1'b0;
        pa_we = 1'b0;
        pa_addr = '0;
        pa_wdata = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mbank = 1'b0;
        mbusy = 1'b0;
        movr = 1'b0;
        mcol = 0;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_en", bus.ram_en, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_wr_bank", wr_bank, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        ram_init = 1'b0;
        @(negedge clock);

        // writer fills bank 0 while bank 1 is on display
        do_line_start();
        for (int c = 0; c < 256; c++)
            wr_pix(c, (c < 4) ? 8'(11 * (c + 1)) : 8'($urandom_range(1, 255)));
        do_line_start();
        for (int c = 0; c < 256; c++)
            wr_pix(c, 8'($urandom_range(1, 255)));

        for (int p = 0; p < LINE_LEN; p++) begin
            do_pix(0);
            gap();
        end
        chk("line_end_busy", busy, 0);
        idle_ce();

        do_line_start();
        chk("bank1_wr_bank", wr_bank, 0);
        for (int c = 0; c < LINE_LEN; c++)
            wr_pix(c, 8'($urandom_range(1, 255)));

        do_pix(0);
        do_pix(0);
        chk("ovr_before", overrun, 0);
        do_pix(1);
        gap();
        do_pix(0);
        do_pix(0);
        chk("ls_capt_col", mcol, 5);
        do_pix(2);
        gap();

        while (mcol < 100) begin
            do_pix(0);
            gap();
        end

        ce_pix = 1'b1;
        #1;
        chk("rst_rd_addr", bus.ram_addr, {mbank, 8'(mcol)});
        @(negedge clock);
        ce_pix = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_no_wr", bus.ram_wr, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        mbank = 1'b0;
        mcol = 0;
        mbusy = 1'b0;
        movr = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_en", bus.ram_en, 0);
        chk("mid_wr_bank", wr_bank, 1);
        chk("mid_valid", pix_valid, 0);
        chk("mid_overrun", overrun, 0);
        idle_ce();
        do_line_start();
        do_pix(0);

        diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== mdl[i]) diffs++;
        chk("mem_state", diffs, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
